// File: rtl/accum_run_sequencer.sv
// Run controller for the ROM-fed accumulator: clear, issue LAT-aligned reads, drain, report done.
// Optional busy-cycle counter on run_cycles when RUN_CYCLES_EN is defined.
module accum_run_sequencer #(
    parameter int ADDR_W = 8,
    parameter int LAT    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              err_busy,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd_en,
    output logic              acc_clear,
    output logic              acc_valid
`ifdef RUN_CYCLES_EN
    ,
    output logic [31:0]       run_cycles
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_W:0] ONE_ENTRY  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [3:0]      DRAIN_LOAD = 4'(LAT - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   rem_q;
    logic [3:0]        drain_q;
    logic [LAT-1:0]    vld_q;

    logic busyState;
    logic takeAbort;
    logic acceptStart;

    assign busyState   = (state_q == S_CLEAR) || (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign takeAbort   = busyState && abort;
    assign acceptStart = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d = state_q;
        if (takeAbort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_d = S_CLEAR;
                S_CLEAR: state_d = (len_q != '0) ? S_ISSUE : S_DONE;
                S_ISSUE: if (rem_q == ONE_ENTRY) state_d = S_DRAIN;
                S_DRAIN: if (drain_q == 4'd0) state_d = S_DONE;
                S_DONE:  state_d = start ? S_CLEAR : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // The address is not advanced past the final read so rom_addr keeps the last issued address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            if (acceptStart) begin
                base_q <= base_addr;
                len_q  <= length;
            end
            if (!takeAbort) begin
                case (state_q)
                    S_CLEAR: begin
                        addr_q <= base_q;
                        rem_q  <= len_q;
                    end
                    S_ISSUE: begin
                        rem_q <= rem_q - ONE_ENTRY;
                        if (rem_q == ONE_ENTRY) begin
                            drain_q <= DRAIN_LOAD;
                        end else begin
                            addr_q <= addr_q + 1'b1;
                        end
                    end
                    S_DRAIN: if (drain_q != 4'd0) drain_q <= drain_q - 4'd1;
                    default: ;
                endcase
            end
        end
    end

    // Valid delay line; an abort flushes it so no stale strobes reach the accumulator.
    always_ff @(posedge clk) begin
        if (rst || takeAbort) begin
            vld_q <= '0;
        end else begin
            vld_q <= (vld_q << 1) | LAT'(rom_rd_en);
        end
    end

`ifdef RUN_CYCLES_EN
    logic [31:0] cyc_q;
    logic [31:0] run_q;

    // The latch adds one because the final busy cycle's increment lands on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
            run_q <= '0;
        end else begin
            if (acceptStart) begin
                cyc_q <= '0;
            end else if (busyState) begin
                cyc_q <= cyc_q + 32'd1;
            end
            if (state_d == S_DONE) begin
                run_q <= cyc_q + 32'd1;
            end
        end
    end

    assign run_cycles = run_q;
`endif

    assign busy      = busyState;
    assign done      = (state_q == S_DONE);
    assign aborted   = takeAbort;
    assign err_busy  = start && busyState && !abort;
    assign rom_addr  = addr_q;
    assign rom_rd_en = (state_q == S_ISSUE);
    assign acc_clear = (state_q == S_CLEAR);
    assign acc_valid = vld_q[LAT-1];

endmodule

// File: tb/tb_accum_run_sequencer.sv
// Directed bench for accum_run_sequencer (ADDR_W=8, LAT=3); run_cycles checks only with RUN_CYCLES_EN.
module tb_accum_run_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] baseAddr;
    logic [8:0] len;
    logic       abortIn;
    logic       busy, done, aborted, errBusy, romRdEn, accClear, accValid;
    logic [7:0] romAddr;
`ifdef RUN_CYCLES_EN
    logic [31:0] runCycles;
`endif

    int checks   = 0;
    int failures = 0;

    int cyc;
    int obsBase;
    int runRd, addrErr;
    int clearCnt, clearCyc;
    int rdCnt, firstRd, lastRd;
    int validCnt, firstValid, lastValid, validGap;
    int doneCnt, doneCyc;
    int abCnt, abCyc;
    int errCnt, errCyc;
    int busyCnt;

    accum_run_sequencer #(.ADDR_W(8), .LAT(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (baseAddr),
        .length    (len),
        .abort     (abortIn),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .err_busy  (errBusy),
        .rom_addr  (romAddr),
        .rom_rd_en (romRdEn),
        .acc_clear (accClear),
        .acc_valid (accValid)
`ifdef RUN_CYCLES_EN
        ,
        .run_cycles(runCycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic clearStats();
        runRd = 0; addrErr = 0;
        clearCnt = 0; clearCyc = -1;
        rdCnt = 0; firstRd = -1; lastRd = -1;
        validCnt = 0; firstValid = -1; lastValid = -1; validGap = 0;
        doneCnt = 0; doneCyc = -1;
        abCnt = 0; abCyc = -1;
        errCnt = 0; errCyc = -1;
        busyCnt = 0;
    endtask

    task automatic resetObs(input int base);
        cyc = 0;
        obsBase = base;
        clearStats();
    endtask

    // Drives one cycle's inputs, records the outputs of that cycle, then advances.
    task automatic applyStimulus(input logic s, input logic [7:0] b, input logic [8:0] l, input logic a);
        logic [7:0] expAddr;
        start = s; baseAddr = b; len = l; abortIn = a;
        #1;
        if (accClear) begin clearCnt++; clearCyc = cyc; runRd = 0; end
        if (romRdEn) begin
            expAddr = 8'(obsBase + runRd);
            if (romAddr !== expAddr) addrErr++;
            if (rdCnt == 0) firstRd = cyc;
            lastRd = cyc; rdCnt++; runRd++;
        end
        if (accValid) begin
            if (validCnt == 0) firstValid = cyc;
            else if (cyc != lastValid + 1) validGap++;
            lastValid = cyc; validCnt++;
        end
        if (done)    begin doneCnt++; doneCyc = cyc; end
        if (aborted) begin abCnt++; abCyc = cyc; end
        if (errBusy) begin errCnt++; errCyc = cyc; end
        if (busy) busyCnt++;
        stepClock();
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'd0, 9'd0, 1'b0);
    endtask

    function automatic logic [31:0] outVec();
        return {17'd0, busy, done, aborted, errBusy, romRdEn, accClear, accValid, romAddr};
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; baseAddr = '0; len = '0; abortIn = 1'b0;
        repeat (3) stepClock();
        rst = 1'b0;
        #1;
        checkOutput("reset_outputs", outVec(), 32'd0);
`ifdef RUN_CYCLES_EN
        checkOutput("reset_run_cycles", runCycles, 32'd0);
`endif
        stepClock();

        // Full run over 200 entries
        resetObs(0);
        applyStimulus(1'b1, 8'd0, 9'd200, 1'b0);
        idle(210);
        checkOutput("t1_clear_cyc", clearCyc, 1);
        checkOutput("t1_clear_cnt", clearCnt, 1);
        checkOutput("t1_first_rd", firstRd, 2);
        checkOutput("t1_last_rd", lastRd, 201);
        checkOutput("t1_rd_cnt", rdCnt, 200);
        checkOutput("t1_addr_err", addrErr, 0);
        checkOutput("t1_first_valid", firstValid, 5);
        checkOutput("t1_last_valid", lastValid, 204);
        checkOutput("t1_valid_cnt", validCnt, 200);
        checkOutput("t1_valid_gap", validGap, 0);
        checkOutput("t1_done_cyc", doneCyc, 205);
        checkOutput("t1_done_cnt", doneCnt, 1);
        checkOutput("t1_addr_hold", romAddr, 199);
`ifdef RUN_CYCLES_EN
        checkOutput("t1_run_cycles", runCycles, 204);
`endif

        // Address wrap
        resetObs(250);
        applyStimulus(1'b1, 8'd250, 9'd10, 1'b0);
        idle(20);
        checkOutput("t2_rd_cnt", rdCnt, 10);
        checkOutput("t2_addr_err", addrErr, 0);
        checkOutput("t2_valid_cnt", validCnt, 10);
        checkOutput("t2_valid_gap", validGap, 0);
        checkOutput("t2_first_valid", firstValid, 5);
        checkOutput("t2_done_cyc", doneCyc, 15);
        checkOutput("t2_addr_hold", romAddr, 3);
`ifdef RUN_CYCLES_EN
        checkOutput("t2_run_cycles", runCycles, 14);
`endif

        // Zero length
        resetObs(0);
        applyStimulus(1'b1, 8'd9, 9'd0, 1'b0);
        idle(8);
        checkOutput("t3_clear_cyc", clearCyc, 1);
        checkOutput("t3_done_cyc", doneCyc, 2);
        checkOutput("t3_rd_cnt", rdCnt, 0);
        checkOutput("t3_valid_cnt", validCnt, 0);
`ifdef RUN_CYCLES_EN
        checkOutput("t3_run_cycles", runCycles, 1);
`endif

        // Abort mid-issue, then a fresh run
        resetObs(0);
        applyStimulus(1'b1, 8'd0, 9'd200, 1'b0);
        idle(49);
        applyStimulus(1'b0, 8'd0, 9'd0, 1'b1);
        checkOutput("t4_abort_cyc", abCyc, 50);
        checkOutput("t4_rd_before_abort", rdCnt, 49);
        checkOutput("t4_no_done", doneCnt, 0);
        clearStats();
        idle(9);
        checkOutput("t4_busy_after", busyCnt, 0);
        checkOutput("t4_rd_after", rdCnt, 0);
        checkOutput("t4_valid_after", validCnt, 0);
        checkOutput("t4_done_after", doneCnt, 0);
`ifdef RUN_CYCLES_EN
        checkOutput("t4_run_cycles_kept", runCycles, 1);
`endif
        clearStats();
        obsBase = 7;
        applyStimulus(1'b1, 8'd7, 9'd5, 1'b0);
        idle(12);
        checkOutput("t4_restart_done_cyc", doneCyc, 70);
        checkOutput("t4_restart_rd_cnt", rdCnt, 5);
        checkOutput("t4_restart_addr_err", addrErr, 0);
        checkOutput("t4_restart_valid_cnt", validCnt, 5);
`ifdef RUN_CYCLES_EN
        checkOutput("t4_run_cycles", runCycles, 9);
`endif

        // Start while busy is rejected without disturbing the run
        resetObs(10);
        applyStimulus(1'b1, 8'd10, 9'd6, 1'b0);
        idle(2);
        applyStimulus(1'b1, 8'd100, 9'd50, 1'b0);
        idle(11);
        checkOutput("t5_err_cyc", errCyc, 3);
        checkOutput("t5_err_cnt", errCnt, 1);
        checkOutput("t5_rd_cnt", rdCnt, 6);
        checkOutput("t5_addr_err", addrErr, 0);
        checkOutput("t5_done_cyc", doneCyc, 11);
`ifdef RUN_CYCLES_EN
        checkOutput("t5_run_cycles", runCycles, 10);
`endif

        // Start and abort together: abort wins
        resetObs(20);
        applyStimulus(1'b1, 8'd20, 9'd20, 1'b0);
        idle(3);
        applyStimulus(1'b1, 8'd55, 9'd9, 1'b1);
        idle(6);
        checkOutput("t5b_abort_cyc", abCyc, 4);
        checkOutput("t5b_err_cnt", errCnt, 0);
        checkOutput("t5b_rd_cnt", rdCnt, 3);
        checkOutput("t5b_addr_err", addrErr, 0);
        checkOutput("t5b_busy_cnt", busyCnt, 4);
        checkOutput("t5b_no_done", doneCnt, 0);

        // Back-to-back runs with start held high, then reset mid-run
        resetObs(0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'd0, 9'd4, 1'b0);
        checkOutput("t6_done_cnt", doneCnt, 2);
        checkOutput("t6_last_done", doneCyc, 18);
        checkOutput("t6_clear_cnt", clearCnt, 3);
        checkOutput("t6_last_clear", clearCyc, 19);
        checkOutput("t6_valid_cnt", validCnt, 8);
        checkOutput("t6_addr_err", addrErr, 0);
        rst = 1'b1;
        applyStimulus(1'b1, 8'd0, 9'd4, 1'b0);
        rst = 1'b0;
        start = 1'b0;
        #1;
        checkOutput("t6_reset_outputs", outVec(), 32'd0);
`ifdef RUN_CYCLES_EN
        checkOutput("t6_reset_run_cycles", runCycles, 32'd0);
`endif
        stepClock();
        cyc++;
        clearStats();
        idle(6);
        checkOutput("t6_no_done_after_reset", doneCnt, 0);
        checkOutput("t6_no_abort_after_reset", abCnt, 0);
        checkOutput("t6_no_valid_after_reset", validCnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
